// File: rtl/activity_monitor.sv
// activity_monitor: per-channel toggle-activity detector with an activity window.
// Each asynchronous toggle line is synchronised and edge-detected. A per-channel
// counter measures how long ago the last edge was seen. The block raises `active`
// while that edge is less than TIMEOUT cycles old, and pulses rise/fall events
// when `active` changes. A sticky `lost` flag records every fall.
// Ports:
//   Clk, Rst_n   clock; asynchronous active-low reset
//   det_toggle   [CHANNELS] asynchronous toggle inputs
//   clr_lost     synchronous clear of all lost bits
//   active       [CHANNELS] registered activity flags
//   any_active   OR of active (combinational from registers)
//   rise_evt     [CHANNELS] one-cycle pulse on the first active cycle
//   fall_evt     [CHANNELS] one-cycle pulse on the first inactive cycle
//   lost         [CHANNELS] sticky, set by fall_evt, cleared by clr_lost
module activity_monitor #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned TIMEOUT     = 50,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [CHANNELS-1:0] det_toggle,
  input  logic                clr_lost,
  output logic [CHANNELS-1:0] active,
  output logic                any_active,
  output logic [CHANNELS-1:0] rise_evt,
  output logic [CHANNELS-1:0] fall_evt,
  output logic [CHANNELS-1:0] lost
);

  localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
  localparam int unsigned ARM_W      = $clog2(ARM_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [ARM_W-1:0] ARM_DONE  = ARM_W'(ARM_CYCLES);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
  logic [CHANNELS-1:0] prev_q, prev_d;
  logic [ARM_W-1:0]    arm_cnt_q, arm_cnt_d;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] active_q, active_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic [CHANNELS-1:0] lost_q, lost_d;
  logic                armed_c;
  logic [CHANNELS-1:0] edge_c;

  // Edges are ignored until the synchronisers have flushed their reset values,
  // so a line held high through reset does not look like activity.
  assign armed_c = (arm_cnt_q == ARM_DONE);
  assign edge_c  = (sync_q[SYNC_STAGES-1] ^ prev_q) & {CHANNELS{armed_c}};

  // Next-state logic for synchroniser, arm counter, activity counters and events.
  always_comb begin
    for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
      sync_d[s] = '0;
    end
    prev_d    = sync_q[SYNC_STAGES-1];
    arm_cnt_d = arm_cnt_q;
    active_d  = '0;
    rise_d    = '0;
    fall_d    = '0;
    lost_d    = lost_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
    end

    sync_d[0] = det_toggle;
    for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end

    if (!armed_c) begin
      arm_cnt_d = arm_cnt_q + ARM_W'(1);
    end

    // Edge restarts the window; otherwise count up and saturate at TIMEOUT.
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (edge_c[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] < TIMEOUT_C) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      active_d[i] = (cnt_d[i] < TIMEOUT_C);
    end

    rise_d = active_d & ~active_q;
    fall_d = ~active_d & active_q;
    // A fall in the same cycle as a clear keeps the flag set.
    lost_d = fall_q | (lost_q & ~{CHANNELS{clr_lost}});
  end

  // State registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q    <= '0;
      arm_cnt_q <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= TIMEOUT_C;
      end
      active_q  <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      lost_q    <= '0;
    end else begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      prev_q    <= prev_d;
      arm_cnt_q <= arm_cnt_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      active_q  <= active_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      lost_q    <= lost_d;
    end
  end

  assign active     = active_q;
  assign any_active = |active_q;
  assign rise_evt   = rise_q;
  assign fall_evt   = fall_q;
  assign lost       = lost_q;

endmodule

// File: tb/tb_activity_monitor.sv
// Directed bench for activity_monitor: a vector table for single-edge windows,
// restarts and lost clearing, then hand sequences for periodic toggling,
// set/clear collision and reset in the middle of an activity window.
module tb_activity_monitor;

  localparam int unsigned CH = 4;

  logic          Clk;
  logic          Rst_n;
  logic [CH-1:0] det_toggle;
  logic          clr_lost;
  logic [CH-1:0] active;
  logic          any_active;
  logic [CH-1:0] rise_evt;
  logic [CH-1:0] fall_evt;
  logic [CH-1:0] lost;

  int n_checks = 0;
  int n_pass   = 0;

  activity_monitor #(
    .CHANNELS   (CH),
    .TIMEOUT    (50),
    .CNT_W      (8),
    .SYNC_STAGES(2)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .det_toggle(det_toggle),
    .clr_lost  (clr_lost),
    .active    (active),
    .any_active(any_active),
    .rise_evt  (rise_evt),
    .fall_evt  (fall_evt),
    .lost      (lost)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [CH-1:0] tog;
    logic          clr;
    int            wait_cyc;
    logic [CH-1:0] exp_active;
    logic [CH-1:0] exp_rise;
    logic [CH-1:0] exp_fall;
    logic [CH-1:0] exp_lost;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int bad;
    int n_fall;
    int n_rise;

    // Each record: drive on a falling edge, wait wait_cyc falling edges, compare.
    vecs[0]  = '{4'b0010, 1'b0,  2, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b0010, 1'b0,  1, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    vecs[2]  = '{4'b0010, 1'b0,  1, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    vecs[3]  = '{4'b0010, 1'b0, 48, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    vecs[4]  = '{4'b0010, 1'b0,  1, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    vecs[5]  = '{4'b0010, 1'b0,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
    vecs[6]  = '{4'b1011, 1'b0,  3, 4'b1001, 4'b1001, 4'b0000, 4'b0010};
    vecs[7]  = '{4'b1011, 1'b0, 10, 4'b1001, 4'b0000, 4'b0000, 4'b0010};
    vecs[8]  = '{4'b1010, 1'b0,  3, 4'b1001, 4'b0000, 4'b0000, 4'b0010};
    vecs[9]  = '{4'b1010, 1'b0, 36, 4'b1001, 4'b0000, 4'b0000, 4'b0010};
    vecs[10] = '{4'b1010, 1'b0,  1, 4'b0001, 4'b0000, 4'b1000, 4'b0010};
    vecs[11] = '{4'b1010, 1'b0,  1, 4'b0001, 4'b0000, 4'b0000, 4'b1010};
    vecs[12] = '{4'b1010, 1'b1,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    vecs[13] = '{4'b1010, 1'b0, 11, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    vecs[14] = '{4'b1010, 1'b0,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0001};

    // Reset state.
    det_toggle = '0;
    clr_lost   = 1'b0;
    Rst_n      = 1'b1;
    #2 Rst_n   = 1'b0;
    #1;
    chk("reset_active", 32'(active), 32'h0);
    chk("reset_any", 32'(any_active), 32'h0);
    chk("reset_lost", 32'(lost), 32'h0);
    chk("reset_evts", 32'({rise_evt, fall_evt}), 32'h0);
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;

    // Idle with no toggles: everything stays quiet.
    bad = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge Clk);
      if (active !== '0 || any_active !== 1'b0 || rise_evt !== '0 ||
          fall_evt !== '0 || lost !== '0) bad++;
    end
    chk("idle_200_cycles", 32'(bad), 32'h0);

    // Vector table.
    foreach (vecs[i]) begin
      det_toggle = vecs[i].tog;
      clr_lost   = vecs[i].clr;
      repeat (vecs[i].wait_cyc) @(negedge Clk);
      chk($sformatf("vec%0d_active", i), 32'(active), 32'(vecs[i].exp_active));
      chk($sformatf("vec%0d_any", i), 32'(any_active), 32'(|vecs[i].exp_active));
      chk($sformatf("vec%0d_rise", i), 32'(rise_evt), 32'(vecs[i].exp_rise));
      chk($sformatf("vec%0d_fall", i), 32'(fall_evt), 32'(vecs[i].exp_fall));
      chk($sformatf("vec%0d_lost", i), 32'(lost), 32'(vecs[i].exp_lost));
    end
    clr_lost = 1'b0;

    // Ch2 toggles every 50 cycles: each new edge lands in the expiry cycle.
    bad = 0;
    for (int c = 0; c <= 253; c++) begin
      @(negedge Clk);
      if (c >= 3 && c <= 252 && (active[2] !== 1'b1 || fall_evt[2] !== 1'b0)) bad++;
      if (c == 253) begin
        chk("p50_final_fall", 32'(fall_evt[2]), 32'h1);
        chk("p50_final_active", 32'(active[2]), 32'h0);
      end
      if (c % 50 == 0 && c <= 200) det_toggle[2] = ~det_toggle[2];
    end
    chk("p50_continuous", 32'(bad), 32'h0);

    // Ch2 toggles every 52 cycles: one fall and one rise per period.
    n_fall = 0;
    n_rise = 0;
    for (int c = 0; c <= 160; c++) begin
      @(negedge Clk);
      if (fall_evt[2] === 1'b1) n_fall++;
      if (rise_evt[2] === 1'b1) n_rise++;
      if (c == 0 || c == 52 || c == 104) det_toggle[2] = ~det_toggle[2];
    end
    chk("p52_fall_count", 32'(n_fall), 32'd3);
    chk("p52_rise_count", 32'(n_rise), 32'd3);

    // Clear everything, then collide a ch3 fall with clr_lost.
    @(negedge Clk);
    clr_lost = 1'b1;
    @(negedge Clk);
    clr_lost = 1'b0;
    chk("pre_collide_lost", 32'(lost), 32'h0);
    for (int c = 0; c <= 57; c++) begin
      @(negedge Clk);
      if (c == 0) det_toggle[3] = ~det_toggle[3];
      if (c == 53) begin
        chk("collide_fall3", 32'(fall_evt), 32'h8);
        clr_lost = 1'b1;
      end
      if (c == 54) begin
        chk("collide_lost_set_wins", 32'(lost), 32'h8);
        chk("collide_active", 32'(active), 32'h0);
        clr_lost = 1'b0;
      end
      if (c == 56) clr_lost = 1'b1;
      if (c == 57) begin
        chk("later_clear_lost", 32'(lost), 32'h0);
        clr_lost = 1'b0;
      end
    end

    // Reset in the middle of a ch0 window, with ch1 lost set.
    for (int c = 0; c <= 60; c++) begin
      @(negedge Clk);
      if (c == 0)  det_toggle[1] = ~det_toggle[1];
      if (c == 40) det_toggle[0] = 1'b1;
      if (c == 60) begin
        chk("pre_reset_active", 32'(active), 32'h1);
        chk("pre_reset_lost", 32'(lost), 32'h2);
      end
    end
    #2 Rst_n = 1'b0;
    #1;
    chk("midrst_active", 32'(active), 32'h0);
    chk("midrst_any", 32'(any_active), 32'h0);
    chk("midrst_lost", 32'(lost), 32'h0);
    chk("midrst_fall", 32'(fall_evt), 32'h0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;

    // ch0 is held high through release: no activity may appear.
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge Clk);
      if (active !== '0 || rise_evt !== '0 || fall_evt !== '0) bad++;
    end
    chk("held_high_no_event", 32'(bad), 32'h0);

    // A genuine toggle after arming is seen with the normal latency.
    det_toggle[0] = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rearm_latency_early", 32'(active), 32'h0);
    @(negedge Clk);
    chk("rearm_active", 32'(active), 32'h1);
    chk("rearm_rise", 32'(rise_evt), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
